// File: rtl/sprite_position_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sprite_position_ctrl
// Purpose  : Debounced, frame-synchronised sprite position from the push buttons.
//            Macro SPRITE_ACCEL_EN adds a per-axis speed ramp capped at MAX_SPEED.
// Revision : 1.0  initial release
// ============================================================================
module sprite_position_ctrl #(
   parameter int WIDTH           = 640,
   parameter int HEIGHT          = 480,
   parameter int BOX_SIZE        = 50,
   parameter int INIT_X          = 50,
   parameter int INIT_Y          = 50,
   parameter int STEP            = 1,
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int MAX_SPEED       = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn_u,
   input  logic       btn_d,
   input  logic       btn_l,
   input  logic       btn_r,
   input  logic       frame_end,
   output logic [9:0] box_x,
   output logic [8:0] box_y,
   output logic       pos_update
);

   localparam int          c_cnt_w   = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(DEBOUNCE_CYCLES - 1);
   localparam logic [10:0] c_lim_x   = 11'(WIDTH - BOX_SIZE);
   localparam logic [10:0] c_lim_y   = 11'(HEIGHT - BOX_SIZE);
   localparam logic [10:0] c_step    = 11'(STEP);

   if ((MAX_SPEED < STEP) || (STEP < 1)) begin : g_param_check
      $error("sprite_position_ctrl: STEP must be >= 1 and <= MAX_SPEED");
   end

   // ------------------------------------------------------------------------
   // Input synchronisers: bit order {r, l, d, u}
   // ------------------------------------------------------------------------
   logic [3:0] w_btn_raw;
   logic [3:0] r_btn_meta;
   logic [3:0] r_btn_sync;
   logic [3:0] w_btn_db;
   logic       r_fe_meta;
   logic       r_fe_sync;
   logic       r_fe_prev;
   logic       w_tick;

   assign w_btn_raw = {btn_r, btn_l, btn_d, btn_u};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_btn_meta <= 4'b0;
         r_btn_sync <= 4'b0;
         r_fe_meta  <= 1'b0;
         r_fe_sync  <= 1'b0;
         r_fe_prev  <= 1'b0;
      end else begin
         r_btn_meta <= w_btn_raw;
         r_btn_sync <= r_btn_meta;
         r_fe_meta  <= frame_end;
         r_fe_sync  <= r_fe_meta;
         r_fe_prev  <= r_fe_sync;
      end
   end

   // Rising edge only, so a long frame_end level still yields one move
   assign w_tick = r_fe_sync & ~r_fe_prev;

   // ------------------------------------------------------------------------
   // Per-button debounce: state flips only after DEBOUNCE_CYCLES of disagreement
   // ------------------------------------------------------------------------
   for (genvar i = 0; i < 4; i++) begin : g_debounce
      logic [c_cnt_w-1:0] r_cnt;
      logic               r_db;

      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            r_cnt <= '0;
            r_db  <= 1'b0;
         end else if (r_btn_sync[i] == r_db) begin
            r_cnt <= '0;
         end else if (r_cnt == c_cnt_max) begin
            r_cnt <= '0;
            r_db  <= ~r_db;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end

      assign w_btn_db[i] = r_db;
   end

   // ------------------------------------------------------------------------
   // Direction decode
   // ------------------------------------------------------------------------
   logic w_y_dec;
   logic w_y_inc;
   logic w_x_dec;
   logic w_x_inc;
   logic w_x_move;
   logic w_y_move;

   assign w_y_dec  = w_btn_db[0] & ~w_btn_db[1];
   assign w_y_inc  = w_btn_db[1] & ~w_btn_db[0];
   assign w_x_dec  = w_btn_db[2] & ~w_btn_db[3];
   assign w_x_inc  = w_btn_db[3] & ~w_btn_db[2];
   assign w_x_move = w_x_dec | w_x_inc;
   assign w_y_move = w_y_dec | w_y_inc;

   // ------------------------------------------------------------------------
   // Speed selection
   // ------------------------------------------------------------------------
   logic [10:0] w_spd_x;
   logic [10:0] w_spd_y;

`ifdef SPRITE_ACCEL_EN
   localparam logic [10:0] c_max_spd = 11'(MAX_SPEED);

   logic [10:0] r_spd_x;
   logic [10:0] r_spd_y;

   function automatic logic [10:0] f_accel(input logic [10:0] spd);
      return (spd >= c_max_spd) ? c_max_spd : spd + 11'd1;
   endfunction

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_spd_x <= c_step;
         r_spd_y <= c_step;
      end else if (w_tick) begin
         r_spd_x <= w_x_move ? f_accel(r_spd_x) : c_step;
         r_spd_y <= w_y_move ? f_accel(r_spd_y) : c_step;
      end
   end

   assign w_spd_x = r_spd_x;
   assign w_spd_y = r_spd_y;
`else
   assign w_spd_x = c_step;
   assign w_spd_y = c_step;
`endif

   // ------------------------------------------------------------------------
   // Clamped position arithmetic, 11 bits wide so neither edge can wrap
   // ------------------------------------------------------------------------
   function automatic logic [10:0] f_move(
      input logic [10:0] coord,
      input logic        inc,
      input logic        dec,
      input logic [10:0] spd,
      input logic [10:0] lim
   );
      logic [10:0] res;
      res = coord;
      if (inc) begin
         res = ((coord + spd) > lim) ? lim : coord + spd;
      end else if (dec) begin
         res = (coord < spd) ? 11'd0 : coord - spd;
      end
      return res;
   endfunction

   logic [10:0] w_next_x;
   logic [10:0] w_next_y;

   assign w_next_x = f_move({1'b0, box_x}, w_x_inc, w_x_dec, w_spd_x, c_lim_x);
   assign w_next_y = f_move({2'b0, box_y}, w_y_inc, w_y_dec, w_spd_y, c_lim_y);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         box_x      <= 10'(INIT_X);
         box_y      <= 9'(INIT_Y);
         pos_update <= 1'b0;
      end else begin
         pos_update <= 1'b0;
         if (w_tick) begin
            box_x      <= w_next_x[9:0];
            box_y      <= w_next_y[8:0];
            pos_update <= (w_next_x != {1'b0, box_x}) || (w_next_y != {2'b0, box_y});
         end
      end
   end

endmodule
`default_nettype wire
